lrwait_queue_ctrl: RTL and testbench

Bank-side controller for the distributed LRWait/SCWait queue. It sits in the TCDM adapter, directly downstream of the per-core qnodes and the interconnect. For each reserved address it keeps a head/tail table of requester metadata, and it drives three things: the bank memory port, SuccUpdates to the old tail, and lock grants to the queue head on WakeUp.

---
 rtl/lrwait_queue_ctrl_if.sv | 40 ++++
 rtl/lrwait_queue_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lrwait_queue_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lrwait_queue_ctrl_if.sv
// Request/response channel between the qnode/interconnect side and the
// LRWait queue controller. The master drives requests and consumes responses.
interface lrwait_queue_ctrl_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MetaWidth = 12
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [AddrWidth-1:0] in_addr;
  logic                 in_write;
  logic [3:0]           in_amo;
  logic [DataWidth-1:0] in_data;
  logic [StrbWidth-1:0] in_strb;
  logic [MetaWidth-1:0] in_meta;
  logic                 in_lrwait;
  logic                 in_valid;
  logic                 in_ready;

  logic [DataWidth-1:0] rsp_data;
  logic                 rsp_error;
  logic [MetaWidth-1:0] rsp_meta;
  logic                 rsp_lrwait;
  logic                 rsp_valid;
  logic                 rsp_ready;

  modport master (
    output in_addr, in_write, in_amo, in_data, in_strb, in_meta, in_lrwait, in_valid,
    input  in_ready,
    input  rsp_data, rsp_error, rsp_meta, rsp_lrwait, rsp_valid,
    output rsp_ready
  );

  modport slave (
    input  in_addr, in_write, in_amo, in_data, in_strb, in_meta, in_lrwait, in_valid,
    output in_ready,
    output rsp_data, rsp_error, rsp_meta, rsp_lrwait, rsp_valid,
    input  rsp_ready
  );
endinterface

// File: rtl/lrwait_queue_ctrl.sv
// Bank-side LRWait/SCWait queue controller. Keeps a head/tail table per
// reserved address, drives the bank port, sends SuccUpdates to the old tail
// and grants the lock to the new head on WakeUp. One response per request,
// always one cycle after acceptance.
module lrwait_queue_ctrl #(
  parameter int unsigned NumSlots  = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MetaWidth = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  lrwait_queue_ctrl_if.slave     bus,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [3:0]             mem_amo_o,
  input  logic [DataWidth-1:0]   mem_rdata_i
);
  localparam int unsigned IdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam logic [3:0]  AmoLrWait = 4'hC;
  localparam logic [3:0]  AmoScWait = 4'hD;

  typedef enum logic [2:0] {
    REQ_PLAIN, REQ_LR_GRANT, REQ_LR_FULL, REQ_LR_SUCC,
    REQ_SC_OK, REQ_SC_FAIL, REQ_WAKE, REQ_WAKE_MISS
  } req_kind_e;

  // Reservation table
  logic [NumSlots-1:0]  tbl_valid_q;
  logic [AddrWidth-1:0] tbl_addr_q [NumSlots];
  logic [MetaWidth-1:0] tbl_head_q [NumSlots];
  logic [MetaWidth-1:0] tbl_tail_q [NumSlots];

  // Response stage (cycle t+1) and read-data hold register
  logic                 s1_valid_q, s1_error_q, s1_lrwait_q, s1_use_rdata_q;
  logic [MetaWidth-1:0] s1_meta_q;
  logic [DataWidth-1:0] s1_data_q;
  logic                 hold_valid_q;
  logic [DataWidth-1:0] hold_data_q;

  logic                 s1_error_d, s1_lrwait_d, s1_use_rdata_d;
  logic [MetaWidth-1:0] s1_meta_d;
  logic [DataWidth-1:0] s1_data_d;

  logic                 accept, hit, full;
  logic [IdxWidth-1:0]  hit_idx, free_idx;
  logic [MetaWidth-1:0] wake_meta;
  req_kind_e            kind;

  assign bus.in_ready = !s1_valid_q || bus.rsp_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign full         = &tbl_valid_q;
  assign wake_meta    = bus.in_data[MetaWidth-1:0];

  // Address lookup among valid entries and lowest-index free slot search.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (tbl_valid_q[i] && tbl_addr_q[i] == bus.in_addr && !hit) begin
        hit     = 1'b1;
        hit_idx = IdxWidth'(i);
      end
    end
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!tbl_valid_q[i]) free_idx = IdxWidth'(i);
    end
  end

  // Classify the incoming request against the table.
  always_comb begin
    kind = REQ_PLAIN;
    if (bus.in_lrwait) begin
      kind = hit ? REQ_WAKE : REQ_WAKE_MISS;
    end else if (bus.in_amo == AmoLrWait) begin
      kind = hit ? REQ_LR_SUCC : (full ? REQ_LR_FULL : REQ_LR_GRANT);
    end else if (bus.in_amo == AmoScWait) begin
      kind = (hit && tbl_head_q[hit_idx] == bus.in_meta) ? REQ_SC_OK : REQ_SC_FAIL;
    end
  end

  // Bank request and next response fields for an accepted request.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_be_o       = '0;
    mem_amo_o      = '0;
    s1_meta_d      = bus.in_meta;
    s1_data_d      = '0;
    s1_error_d     = 1'b0;
    s1_lrwait_d    = 1'b0;
    s1_use_rdata_d = 1'b0;
    if (accept) begin
      unique case (kind)
        REQ_PLAIN: begin
          mem_req_o      = 1'b1;
          mem_we_o       = bus.in_write;
          mem_addr_o     = bus.in_addr;
          mem_wdata_o    = bus.in_data;
          mem_be_o       = bus.in_strb;
          mem_amo_o      = bus.in_amo;
          s1_use_rdata_d = !bus.in_write;
        end
        REQ_LR_GRANT: begin
          mem_req_o      = 1'b1;
          mem_addr_o     = bus.in_addr;
          s1_use_rdata_d = 1'b1;
        end
        REQ_LR_SUCC: begin
          s1_meta_d   = tbl_tail_q[hit_idx];
          s1_data_d   = DataWidth'(bus.in_meta);
          s1_lrwait_d = 1'b1;
        end
        REQ_SC_OK: begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = bus.in_addr;
          mem_wdata_o = bus.in_data;
          mem_be_o    = bus.in_strb;
        end
        REQ_SC_FAIL: s1_data_d = DataWidth'(1);
        REQ_WAKE: begin
          mem_req_o      = 1'b1;
          mem_addr_o     = tbl_addr_q[hit_idx];
          s1_meta_d      = wake_meta;
          s1_use_rdata_d = 1'b1;
        end
        default: s1_error_d = 1'b1;  // full table or WakeUp without entry
      endcase
    end
  end

  // Entry valid bits: allocate on grant, free on release by the sole holder.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      tbl_valid_q <= '0;
    end else if (accept) begin
      if (kind == REQ_LR_GRANT) tbl_valid_q[free_idx] <= 1'b1;
      if (kind == REQ_SC_OK && tbl_head_q[hit_idx] == tbl_tail_q[hit_idx]) begin
        tbl_valid_q[hit_idx] <= 1'b0;
      end
    end
  end

  // Entry payload: address, head and tail metadata.
  // NOTE: payload is not reset; it is only ever read behind its valid bit.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      unique case (kind)
        REQ_LR_GRANT: begin
          tbl_addr_q[free_idx] <= bus.in_addr;
          tbl_head_q[free_idx] <= bus.in_meta;
          tbl_tail_q[free_idx] <= bus.in_meta;
        end
        REQ_LR_SUCC: tbl_tail_q[hit_idx] <= bus.in_meta;
        REQ_WAKE:    tbl_head_q[hit_idx] <= wake_meta;
        default: ;
      endcase
    end
  end

  // Response stage: loads whenever the previous response has left.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q     <= 1'b0;
      s1_meta_q      <= '0;
      s1_data_q      <= '0;
      s1_error_q     <= 1'b0;
      s1_lrwait_q    <= 1'b0;
      s1_use_rdata_q <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_meta_q      <= s1_meta_d;
        s1_data_q      <= s1_data_d;
        s1_error_q     <= s1_error_d;
        s1_lrwait_q    <= s1_lrwait_d;
        s1_use_rdata_q <= s1_use_rdata_d;
      end
    end
  end

  // Capture the one-cycle bank read data the first cycle a response stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (bus.in_ready) begin
      hold_valid_q <= 1'b0;
    end else if (!hold_valid_q) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= mem_rdata_i;
    end
  end

  assign bus.rsp_valid  = s1_valid_q;
  assign bus.rsp_meta   = s1_meta_q;
  assign bus.rsp_error  = s1_error_q;
  assign bus.rsp_lrwait = s1_lrwait_q;
  assign bus.rsp_data   = s1_use_rdata_q ? (hold_valid_q ? hold_data_q : mem_rdata_i) : s1_data_q;

  // A WakeUp must always find its reservation.
  wake_hit_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(accept && bus.in_lrwait && !hit));

endmodule

// File: tb/tb_lrwait_queue_ctrl.sv
// Self-checking bench for lrwait_queue_ctrl: directed scenarios followed by
// random traffic, checked through a scoreboard fed by a queue-based model.
module tb_lrwait_queue_ctrl;
  localparam int unsigned NumSlots  = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned MetaWidth = 12;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [11:0] meta;
    logic        lrwait;
  } req_t;

  typedef struct {
    logic [11:0] meta;
    logic [31:0] data;
    logic        error;
    logic        lrwait;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o, mem_amo_o;
  logic [31:0] mem_rdata_i = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit bp_random = 1'b0;

  rsp_t sb[$];

  // Bank contents and model state
  logic [31:0] bank    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] m_addr  [NumSlots];
  bit          m_used  [NumSlots];
  bit          m_rel   [NumSlots];
  logic [11:0] m_q     [NumSlots][$];

  lrwait_queue_ctrl_if #(.AddrWidth(AddrWidth), .DataWidth(DataWidth), .MetaWidth(MetaWidth)) bus_if ();

  lrwait_queue_ctrl #(
    .NumSlots(NumSlots), .AddrWidth(AddrWidth), .DataWidth(DataWidth), .MetaWidth(MetaWidth)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_if),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_amo_o(mem_amo_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h0000_9E37) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bank_rd(input logic [31:0] a);
    return bank.exists(a) ? bank[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Bank: 1-cycle read latency, read data only meaningful for one cycle.
  always @(posedge clk_i) begin
    if (mem_req_o && !mem_we_o) mem_rdata_i <= bank_rd(mem_addr_o);
    else                        mem_rdata_i <= $urandom;
    if (mem_req_o && mem_we_o) bank[mem_addr_o] = merge(bank_rd(mem_addr_o), mem_wdata_o, mem_be_o);
  end

  // Random response backpressure
  always @(posedge clk_i) begin
    #2;
    if (bp_random) bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare every presented response with the scoreboard head.
  always @(negedge clk_i) begin
    if (rst_ni && bus_if.rsp_valid) begin
      if (sb.size() == 0) begin
        fail("rsp_unexpected");
      end else begin
        check("rsp_meta",   bus_if.rsp_meta,   sb[0].meta);
        check("rsp_data",   bus_if.rsp_data,   sb[0].data);
        check("rsp_error",  bus_if.rsp_error,  sb[0].error);
        check("rsp_lrwait", bus_if.rsp_lrwait, sb[0].lrwait);
        if (bus_if.rsp_ready) void'(sb.pop_front());
      end
    end
  end

  // ---------------- reference model: one waiter queue per reserved address
  function automatic int find_slot(input logic [31:0] a);
    for (int i = 0; i < NumSlots; i++) if (m_used[i] && m_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic int free_slot();
    for (int i = 0; i < NumSlots; i++) if (!m_used[i]) return i;
    return -1;
  endfunction

  function automatic bit meta_busy(input logic [11:0] m);
    for (int i = 0; i < NumSlots; i++)
      if (m_used[i]) foreach (m_q[i][j]) if (m_q[i][j] == m) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NumSlots; i++) begin
      m_used[i] = 1'b0;
      m_rel[i]  = 1'b0;
      m_q[i].delete();
    end
  endtask

  task automatic model_step(input req_t r, output rsp_t e, output logic [1:0] mreq);
    int s = find_slot(r.addr);
    int f;
    e.meta = r.meta; e.data = '0; e.error = 1'b0; e.lrwait = 1'b0;
    mreq = 2'b00;
    if (r.lrwait) begin
      if (s < 0) begin
        e.error = 1'b1;
      end else begin
        void'(m_q[s].pop_front());
        if (m_q[s].size() == 0) m_q[s].push_back(r.data[11:0]);
        else                    m_q[s][0] = r.data[11:0];
        m_rel[s] = 1'b0;
        e.meta = r.data[11:0];
        e.data = ref_rd(m_addr[s]);
        mreq = 2'b10;
      end
    end else if (r.amo == 4'hC) begin
      if (s >= 0) begin
        e.meta   = m_q[s][$];
        e.data   = {20'h0, r.meta};
        e.lrwait = 1'b1;
        m_q[s].push_back(r.meta);
      end else begin
        f = free_slot();
        if (f < 0) begin
          e.error = 1'b1;
        end else begin
          m_used[f] = 1'b1; m_addr[f] = r.addr; m_rel[f] = 1'b0;
          m_q[f].delete(); m_q[f].push_back(r.meta);
          e.data = ref_rd(r.addr);
          mreq = 2'b10;
        end
      end
    end else if (r.amo == 4'hD) begin
      if (s >= 0 && m_q[s][0] == r.meta) begin
        ref_mem[r.addr] = merge(ref_rd(r.addr), r.data, r.strb);
        mreq = 2'b11;
        if (m_q[s].size() == 1) begin
          m_used[s] = 1'b0; m_rel[s] = 1'b0; m_q[s].delete();
        end else begin
          m_rel[s] = 1'b1;
        end
      end else begin
        e.data = 32'd1;
      end
    end else begin
      mreq = {1'b1, r.write};
      if (r.write) ref_mem[r.addr] = merge(ref_rd(r.addr), r.data, r.strb);
      else         e.data = ref_rd(r.addr);
    end
  endtask

  // ---------------- stimulus helpers
  function automatic req_t mk(input logic [31:0] a, input logic w, input logic [3:0] amo,
                              input logic [31:0] d, input logic [3:0] be, input logic [11:0] m,
                              input logic lw);
    req_t r;
    r.addr = a; r.write = w; r.amo = amo; r.data = d; r.strb = be; r.meta = m; r.lrwait = lw;
    return r;
  endfunction

  function automatic req_t mk_lr(input logic [31:0] a, input logic [11:0] m);
    return mk(a, 1'b0, 4'hC, 32'h0, 4'h0, m, 1'b0);
  endfunction

  function automatic req_t mk_sc(input logic [31:0] a, input logic [11:0] m, input logic [31:0] d);
    return mk(a, 1'b0, 4'hD, d, 4'hF, m, 1'b0);
  endfunction

  function automatic req_t mk_wake(input logic [31:0] a, input logic [11:0] m, input logic [11:0] nxt);
    return mk(a, 1'b0, 4'h0, {20'h0, nxt}, 4'h0, m, 1'b1);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    bank[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic send(input req_t r);
    rsp_t       e;
    logic [1:0] mreq;
    int         waited = 0;
    bit         accepted = 1'b0;
    bus_if.in_addr = r.addr; bus_if.in_write = r.write; bus_if.in_amo = r.amo;
    bus_if.in_data = r.data; bus_if.in_strb = r.strb; bus_if.in_meta = r.meta;
    bus_if.in_lrwait = r.lrwait; bus_if.in_valid = 1'b1;
    while (!accepted) begin
      @(negedge clk_i);
      if (bus_if.in_ready) begin
        accepted = 1'b1;
      end else begin
        waited++;
        if (waited > 100) begin
          fail("send_timeout");
          bus_if.in_valid = 1'b0;
          return;
        end
      end
    end
    model_step(r, e, mreq);
    sb.push_back(e);
    check("mem_req_we", {mem_req_o, mem_we_o}, mreq);
    @(posedge clk_i);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk_i);
      w++;
    end
    if (sb.size() != 0) fail("drain_timeout");
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready",  bus_if.in_ready, 1);
    check("rst_rsp_valid", bus_if.rsp_valid, 0);
    check("rst_rsp_bits",  {bus_if.rsp_meta, bus_if.rsp_error, bus_if.rsp_lrwait}, 0);
    check("rst_rsp_data",  bus_if.rsp_data, 0);
    check("rst_mem_ctrl",  {mem_req_o, mem_we_o, mem_be_o, mem_amo_o}, 0);
    check("rst_mem_addr",  mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
  endtask

  // ---------------- main sequence
  localparam logic [31:0] A = 32'h100;

  initial begin
    bus_if.in_valid = 1'b0; bus_if.in_addr = '0; bus_if.in_write = 1'b0; bus_if.in_amo = '0;
    bus_if.in_data = '0; bus_if.in_strb = '0; bus_if.in_meta = '0; bus_if.in_lrwait = 1'b0;
    bus_if.rsp_ready = 1'b1;
    model_reset();
    #2;
    check_reset_outputs();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Basic grant and release
    preload(A, 32'h55);
    send(mk_lr(A, 12'h011));
    send(mk_sc(A, 12'h011, 32'h7));
    drain();
    check("sc_bank_word", bank_rd(A), 32'h7);

    // Queueing, wrong-owner SCWAIT, wake-up
    send(mk_lr(A, 12'h011));
    send(mk_lr(A, 12'h022));
    send(mk_sc(A, 12'h022, 32'hDEAD));
    send(mk_sc(A, 12'h011, 32'h99));
    send(mk_wake(A, 12'h011, 12'h022));
    drain();
    check("wrong_owner_no_write", bank_rd(A), 32'h99);

    // Full table: A plus three more, then a fifth address
    send(mk_lr(32'h200, 12'h033));
    send(mk_lr(32'h300, 12'h044));
    send(mk_lr(32'h400, 12'h055));
    send(mk_lr(32'h500, 12'h066));
    send(mk_sc(A, 12'h022, 32'h1));
    send(mk_sc(32'h200, 12'h033, 32'h2));
    send(mk_sc(32'h300, 12'h044, 32'h3));
    send(mk_sc(32'h400, 12'h055, 32'h4));
    drain();

    // Backpressure on a grant: response held for 3 cycles
    preload(32'h600, 32'hCAFE_F00D);
    send(mk_lr(32'h600, 12'h077));
    bus_if.rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("bp_in_ready", bus_if.in_ready, 0);
    end
    @(posedge clk_i);
    #1 bus_if.rsp_ready = 1'b1;
    @(posedge clk_i);
    check("bp_delivered_once", sb.size(), 0);
    #1;
    send(mk_sc(32'h600, 12'h077, 32'h0));
    drain();

    // Reset with two queued waiters on A and a stalled response in flight
    send(mk_lr(A, 12'h011));
    send(mk_lr(A, 12'h022));
    send(mk_lr(32'h200, 12'h033));
    drain();
    bus_if.rsp_ready = 1'b0;
    send(mk_lr(32'h300, 12'h044));
    rst_ni = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    bus_if.rsp_ready = 1'b1;
    send(mk_lr(A, 12'h088));
    send(mk_lr(32'h200, 12'h011));
    send(mk_sc(A, 12'h088, 32'h5));
    send(mk_sc(32'h200, 12'h011, 32'h6));
    drain();

    // Random traffic
    bp_random = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int          k = $urandom_range(0, 99);
      logic [31:0] a = 32'h1000 + 32'h40 * $urandom_range(0, 5);
      logic [11:0] m = 12'h0A0 + 12'($urandom_range(0, 7));
      int          cand[$];
      req_t        r;
      r = mk(a, 1'b0, 4'h0, '0, '0, m, 1'b0);
      if (k < 35) begin
        for (int t = 0; t < 8 && meta_busy(m); t++) m = 12'h0A0 + 12'($urandom_range(0, 7));
        if (!meta_busy(m)) r = mk_lr(a, m);
      end else if (k < 60) begin
        for (int i = 0; i < NumSlots; i++) if (m_used[i]) cand.push_back(i);
        if (cand.size() != 0 && $urandom_range(0, 3) != 0) begin
          int s = cand[$urandom_range(0, cand.size() - 1)];
          r = mk_sc(m_addr[s], m_q[s][0], $urandom);
        end else begin
          r = mk_sc(a, m, $urandom);
        end
        r.strb = 4'($urandom_range(1, 15));
      end else if (k < 75) begin
        for (int i = 0; i < NumSlots; i++) if (m_used[i] && m_rel[i]) cand.push_back(i);
        if (cand.size() != 0) begin
          int s = cand[$urandom_range(0, cand.size() - 1)];
          r = mk_wake(m_addr[s], m_q[s][0], m_q[s][1]);
        end
      end else begin
        r.write = $urandom_range(0, 1);
        r.data  = $urandom;
        r.strb  = 4'($urandom_range(1, 15));
      end
      send(r);
    end
    bp_random = 1'b0;
    #3 bus_if.rsp_ready = 1'b1;
    drain();
    check("final_pending", sb.size(), 0);
    foreach (ref_mem[a]) check("final_mem", bank_rd(a), ref_mem[a]);
    foreach (bank[a]) check("final_bank", bank[a], ref_rd(a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
